// File: rtl/nonce_result_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nonce_result_scanner
//
// Purpose
//   Scans NUM_NONCES consecutive 32-bit hash result words from a synchronous
//   memory, finds the smallest word (lowest index wins on ties), counts the
//   words strictly below a difficulty target, then writes a two-word summary
//   back to memory and pulses done for one cycle.
//
//   Memory timing: an address registered on edge k returns its word on
//   mem_read_data in time to be captured on edge k+2. Reads are issued one per
//   cycle with no wait states, so capture runs one edge behind issue.
//
//   Summary layout (written at result_addr, result_addr+1):
//     word 0 : best_hash
//     word 1 : {found, 20'b0, pass_count[5:0], best_nonce[4:0]}
//
// Ports
//   clk             in   1   single clock, all state changes on rising edge
//   reset           in   1   synchronous, active-high
//   start           in   1   begin a scan (only looked at in IDLE)
//   hash_addr       in   16  address of the word for nonce 0
//   result_addr     in   16  base address of the two-word summary
//   target          in   32  unsigned threshold, stable from start to done
//   mem_clk         out  1   memory clock (same as clk)
//   mem_we          out  1   memory write enable (summary writes only)
//   mem_addr        out  16  registered memory address
//   mem_write_data  out  32  registered memory write data
//   mem_read_data   in   32  memory read data
//   done            out  1   one-cycle completion pulse
//   found           out  1   at least one word strictly below target
//   best_nonce      out  5   index of the minimum word
//   best_hash       out  32  value of the minimum word
//   pass_count      out  6   number of words strictly below target
// -----------------------------------------------------------------------------
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        done,
    output logic        found,
    output logic [4:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic [5:0]  pass_count
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // The scan counter holds (edges spent in SCAN) - 1. Its value before an
    // edge tells us which step of the pipelined read that edge performs.
    //   issue  : counter <  NUM_NONCES-1  -> advance mem_addr
    //   capture: counter >= 1             -> word (counter-1) is on the bus
    //   leave  : counter == NUM_NONCES    -> last word captured this edge
    localparam logic [5:0] ISSUE_LAST = 6'(NUM_NONCES - 1);
    localparam logic [5:0] LAST_CNT   = 6'(NUM_NONCES);
    localparam logic [31:0] HASH_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        WR_HASH  = 3'd2,
        WR_NONCE = 3'd3,
        FINISH   = 3'd4
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [5:0]  scan_cnt_q, scan_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic [4:0]  best_nonce_q, best_nonce_d;
    logic [31:0] best_hash_q, best_hash_d;
    logic [5:0]  pass_count_q, pass_count_d;

    // Capture-side decode for the current SCAN edge.
    logic        capture;
    logic [4:0]  word_idx;

    assign capture  = (state_q == SCAN) && (scan_cnt_q != 6'd0);
    // Counter value N means word N-1 is on the bus; 5-bit wrap maps 32 -> 31.
    assign word_idx = 5'(scan_cnt_q - 6'd1);

    // -------------------------------------------------------------------------
    // Process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of all others, matching hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = SCAN;
            SCAN:     if (scan_cnt_q == LAST_CNT) state_d = WR_HASH;
            WR_HASH:  state_d = WR_NONCE;
            WR_NONCE: state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output / datapath next-value logic
    // -------------------------------------------------------------------------
    // mem_we and done default low: they are only raised by the summary writes
    // and the FINISH step, and drop again on the following edge. Every other
    // register holds unless a state explicitly changes it.
    always_comb begin
        scan_cnt_d   = scan_cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        found_d      = found_q;
        best_nonce_d = best_nonce_q;
        best_hash_d  = best_hash_q;
        pass_count_d = pass_count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Issue the read for word 0 and clear the results.
                    scan_cnt_d   = 6'd0;
                    mem_addr_d   = hash_addr;
                    best_hash_d  = HASH_INIT;
                    best_nonce_d = 5'd0;
                    pass_count_d = 6'd0;
                    found_d      = 1'b0;
                end
            end

            SCAN: begin
                scan_cnt_d = scan_cnt_q + 6'd1;

                // Issue side: one new address per cycle, then hold.
                if (scan_cnt_q < ISSUE_LAST) begin
                    mem_addr_d = mem_addr_q + 16'd1;
                end

                // Capture side. Strict compare keeps the earlier index on ties.
                if (capture) begin
                    if (mem_read_data < best_hash_q) begin
                        best_hash_d  = mem_read_data;
                        best_nonce_d = word_idx;
                    end
                    if (mem_read_data < target) begin
                        pass_count_d = pass_count_q + 6'd1;
                        found_d      = 1'b1;
                    end
                end
            end

            WR_HASH: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = result_addr;
                mem_wdata_d = best_hash_q;
            end

            WR_NONCE: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = result_addr + 16'd1;
                mem_wdata_d = {found_q, 20'b0, pass_count_q, best_nonce_q};
            end

            FINISH: begin
                done_d = 1'b1;
            end

            default: begin
                // Unreachable encodings fall back to IDLE via the state logic;
                // the datapath simply holds with writes disabled.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q   <= 6'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 32'd0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            best_nonce_q <= 5'd0;
            best_hash_q  <= HASH_INIT;
            pass_count_q <= 6'd0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            found_q      <= found_d;
            best_nonce_q <= best_nonce_d;
            best_hash_q  <= best_hash_d;
            pass_count_q <= pass_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign done           = done_q;
    assign found          = found_q;
    assign best_nonce     = best_nonce_q;
    assign best_hash      = best_hash_q;
    assign pass_count     = pass_count_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_nonce_result_scanner
//
// Drives scans into nonce_result_scanner against a memory model. For each
// accepted start the expected result (from a plain min/count model over the
// memory window) is queued; a monitor pops it when done is seen and compares
// outputs, completion cycle and the two summary writes.
// -----------------------------------------------------------------------------
module tb_nonce_result_scanner;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        done;
    logic        found;
    logic [4:0]  best_nonce;
    logic [31:0] best_hash;
    logic [5:0]  pass_count;

    nonce_result_scanner #(.NUM_NONCES(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .hash_addr      (hash_addr),
        .result_addr    (result_addr),
        .target         (target),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .done           (done),
        .found          (found),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash),
        .pass_count     (pass_count)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard types and state
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] bh;
        logic [4:0]  bn;
        logic [5:0]  pc;
        logic        f;
    } res_t;

    typedef struct {
        res_t        r;
        logic [15:0] raddr;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t        sb[$];
    wr_t         wq[$];
    logic [31:0] mem [0:65535];
    int          cyc       = 0;
    int          done_seen = 0;
    int          want_done = 0;
    int          n_cmp     = 0;
    int          n_err     = 0;
    res_t        last_res;
    bit          have_last = 0;
    logic [31:0] last_w1   = '0;

    // Synchronous read memory: address registered on edge k is sampled here
    // on edge k+1, so the DUT sees the word on edge k+2.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        cyc           <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: minimum value, first index holding it, count below target
    // -------------------------------------------------------------------------
    function automatic res_t model(input logic [15:0] base, input logic [31:0] tgt);
        res_t        r;
        logic [31:0] w [N];
        logic [31:0] mn;
        int          cnt;
        mn  = 32'hFFFF_FFFF;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            w[i] = mem[16'(base + 16'(i))];
            if (w[i] < mn) mn = w[i];
            if (w[i] < tgt) cnt++;
        end
        r.bh = mn;
        r.bn = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w[i] == mn) r.bn = 5'(i);
        end
        r.pc = 6'(cnt);
        r.f  = (cnt != 0);
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Monitor: summary writes and completion
    // -------------------------------------------------------------------------
    always @(negedge clk) begin : mon
        exp_t e;
        wr_t  w;
        if (mem_we) wq.push_back('{mem_addr, mem_write_data});
        if (done) begin
            done_seen++;
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("best_hash", 64'(best_hash), 64'(e.r.bh));
                check("best_nonce", 64'(best_nonce), 64'(e.r.bn));
                check("pass_count", 64'(pass_count), 64'(e.r.pc));
                check("found", 64'(found), 64'(e.r.f));
                check("summary_write_count", 64'(wq.size()), 64'd2);
                if (wq.size() >= 2) begin
                    w = wq.pop_front();
                    check("summary0_addr", 64'(w.a), 64'(e.raddr));
                    check("summary0_data", 64'(w.d), 64'(e.r.bh));
                    w = wq.pop_front();
                    check("summary1_addr", 64'(w.a), 64'(16'(e.raddr + 16'd1)));
                    check("summary1_data", 64'(w.d),
                          64'({e.r.f, 20'b0, e.r.pc, e.r.bn}));
                    last_w1 = w.d;
                end
                last_res  = e.r;
                have_last = 1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers (all called at a negedge)
    // -------------------------------------------------------------------------
    task automatic wait_done(input int want);
        int k = 0;
        while (done_seen < want && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_arrived", 64'(done_seen >= want), 64'd1);
    endtask

    task automatic check_hold();
        if (have_last) begin
            check("hold_best_hash", 64'(best_hash), 64'(last_res.bh));
            check("hold_best_nonce", 64'(best_nonce), 64'(last_res.bn));
            check("hold_pass_count", 64'(pass_count), 64'(last_res.pc));
            check("hold_found", 64'(found), 64'(last_res.f));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_found"}, 64'(found), 64'd0);
        check({tag, "_best_nonce"}, 64'(best_nonce), 64'd0);
        check({tag, "_best_hash"}, 64'(best_hash), 64'hFFFF_FFFF);
        check({tag, "_pass_count"}, 64'(pass_count), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_write_data), 64'd0);
    endtask

    task automatic put(input logic [15:0] base, input int i, input logic [31:0] v);
        mem[16'(base + 16'(i))] = v;
    endtask

    task automatic scan(input logic [15:0] base, input logic [15:0] raddr,
                        input logic [31:0] tgt, input bit pulse_mid);
        exp_t e;
        check_hold();
        hash_addr   = base;
        result_addr = raddr;
        target      = tgt;
        start       = 1'b1;
        e.r         = model(base, tgt);
        e.raddr     = raddr;
        e.done_cyc  = cyc + 1 + N + 4;
        sb.push_back(e);
        want_done++;
        @(negedge clk);
        start = 1'b0;
        if (pulse_mid) begin
            // A start during SCAN with different addresses must be ignored.
            repeat (4) @(negedge clk);
            hash_addr   = ~base;
            result_addr = ~raddr;
            start       = 1'b1;
            @(negedge clk);
            start       = 1'b0;
            hash_addr   = base;
            result_addr = raddr;
        end
        wait_done(want_done);
    endtask

    // start held high through done: a second scan begins on the edge after done.
    task automatic scan_b2b(input logic [15:0] base, input logic [15:0] raddr,
                            input logic [31:0] tgt);
        exp_t e;
        int   d1;
        check_hold();
        hash_addr   = base;
        result_addr = raddr;
        target      = tgt;
        start       = 1'b1;
        e.r         = model(base, tgt);
        e.raddr     = raddr;
        d1          = cyc + 1 + N + 4;
        e.done_cyc  = d1;
        sb.push_back(e);
        e.done_cyc  = d1 + 1 + N + 4;
        sb.push_back(e);
        want_done  += 2;
        while (cyc < d1 + 1) @(negedge clk);
        start = 1'b0;
        wait_done(want_done);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, done_seen=%0d want=%0d", done_seen, want_done);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [15:0] base;
        logic [31:0] tgt;
        logic [31:0] v;
        int          mode;
        int          accept;

        reset       = 1'b1;
        start       = 1'b0;
        hash_addr   = '0;
        result_addr = '0;
        target      = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check("mem_clk_low", 64'(mem_clk), 64'(clk));
        reset = 1'b0;
        @(negedge clk);

        // Ascending words, target 1: nothing passes, word 0 is the minimum.
        for (int i = 0; i < N; i++) put(16'h0100, i, 32'h1000_0000 + 32'(i * 16));
        scan(16'h0100, 16'h0800, 32'h0000_0001, 1'b0);
        check("asc_best_hash", 64'(best_hash), 64'h1000_0000);
        check("asc_pass_count", 64'(pass_count), 64'd0);
        check("asc_found", 64'(found), 64'd0);
        check("asc_summary1", 64'(last_w1), 64'h0);

        // Two words below target, minimum at index 9.
        for (int i = 0; i < N; i++) put(16'h0200, i, 32'hFFFF_0000);
        put(16'h0200, 9, 32'h0000_00FF);
        put(16'h0200, 3, 32'h0000_FFFF);
        scan(16'h0200, 16'h0810, 32'h0001_0000, 1'b0);
        check("two_pass_best_nonce", 64'(best_nonce), 64'd9);
        check("two_pass_summary1", 64'(last_w1), 64'h8000_0049);

        // Tie at indices 4 and 11 keeps the lower index.
        for (int i = 0; i < N; i++) put(16'h0300, i, 32'h0000_1000 + 32'(i));
        put(16'h0300, 4, 32'h0000_0010);
        put(16'h0300, 11, 32'h0000_0010);
        scan(16'h0300, 16'h0820, 32'h0000_0000, 1'b0);
        check("tie_best_nonce", 64'(best_nonce), 64'd4);

        // Reset on SCAN edge 8: no writes, no done, then a clean rerun.
        hash_addr   = 16'h0300;
        result_addr = 16'h0830;
        target      = 32'h0000_2000;
        start       = 1'b1;
        accept      = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < accept + 7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        reset     = 1'b0;
        have_last = 0;
        repeat (30) @(negedge clk);
        check("abort_no_writes", 64'(wq.size()), 64'd0);
        check("abort_no_done", 64'(done_seen), 64'(want_done));
        scan(16'h0300, 16'h0830, 32'h0000_2000, 1'b0);

        // Address wrap FFF8..0007 with a start pulse mid-scan. Smaller words
        // just outside the window must not be picked up.
        put(16'hFFF8, -1, 32'h0000_0000);
        put(16'hFFF8, N, 32'h0000_0000);
        for (int i = 0; i < N; i++) put(16'hFFF8, i, 32'h0100_0000 + 32'(i * 3));
        put(16'hFFF8, 11, 32'h0000_0055);
        put(16'hFFF8, 2, 32'h0000_0080);
        scan(16'hFFF8, 16'hFFFF, 32'h0000_0100, 1'b1);
        check("wrap_best_nonce", 64'(best_nonce), 64'd11);
        check("wrap_best_hash", 64'(best_hash), 64'h55);
        repeat (40) @(negedge clk);
        check("wrap_no_extra_scan", 64'(done_seen), 64'(want_done));

        // start held across done.
        for (int i = 0; i < N; i++) put(16'h0400, i, $urandom);
        scan_b2b(16'h0400, 16'h0840, 32'h8000_0000);

        // Randomised scans.
        for (int t = 0; t < 24; t++) begin
            base = 16'($urandom);
            mode = t % 4;
            v    = $urandom_range(0, 1000);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: put(base, i, $urandom);
                    1: put(base, i, $urandom_range(0, 63));
                    2: put(base, i, v);
                    default: put(base, i, $urandom_range(0, 3));
                endcase
            end
            case (mode)
                0: tgt = $urandom;
                1: tgt = $urandom_range(0, 64);
                2: tgt = v + 32'd1;
                default: tgt = 32'd0;
            endcase
            scan(base, 16'(base + 16'h4000), tgt, (t % 5) == 0);
        end

        repeat (30) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("no_stray_writes", 64'(wq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nonce_result_scanner.md
NONCE_RESULT_SCANNER -- requirements
Module: nonce_result_scanner

Interface
REQ-001 Parameter NUM_NONCES, default 16, number of consecutive hash result words to scan (range 1..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 start  input  1  begin scan; sampled only in IDLE.
REQ-005 hash_addr  input  16  base address of result word for nonce 0 (word i at hash_addr+i).
REQ-006 result_addr  input  16  base address of the 2-word summary written at end of scan.
REQ-007 target  input  32  unsigned difficulty threshold; held stable from start until done.
REQ-008 mem_clk  output  1  tied to clk.
REQ-009 mem_we  output  1  memory write enable.
REQ-010 mem_addr  output  16  memory address, registered.
REQ-011 mem_write_data  output  32  memory write data, registered.
REQ-012 mem_read_data  input  32  memory read data; word at an address registered on edge k is captured on edge k+2.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 found  output  1  at least one word strictly below target.
REQ-015 best_nonce  output  5  index of minimum hash word.
REQ-016 best_hash  output  32  minimum hash word value.
REQ-017 pass_count  output  6  number of words strictly below target.

Function
REQ-018 FSM states: IDLE, SCAN, WR_HASH, WR_NONCE, FINISH; any unused encoding SHALL return to IDLE.
REQ-019 IDLE with start=1 (edge 0): mem_addr<=hash_addr, mem_we<=0, best_hash<=32'hFFFFFFFF, best_nonce<=0, pass_count<=0, found<=0, go SCAN; start=0 stays IDLE.
REQ-020 SCAN: edges 1..NUM_NONCES-1 increment mem_addr by 1 (pipelined, one issue per cycle, no wait states); mem_addr holds after last issue.
REQ-021 SCAN: edges 2..NUM_NONCES+1 capture word i=(edge-2) from mem_read_data.
REQ-022 Per captured word: if word < best_hash (unsigned), update best_hash and best_nonce<=i; ties keep the lower index.
REQ-023 Per captured word: if word < target (unsigned, strict), pass_count increments; found<=1.
REQ-024 Edge NUM_NONCES+1: after last capture go WR_HASH.
REQ-025 WR_HASH edge: mem_we<=1, mem_addr<=result_addr, mem_write_data<=best_hash (including last-word update), go WR_NONCE.
REQ-026 WR_NONCE edge: mem_we<=1, mem_addr<=result_addr+1, mem_write_data<={found, 20'b0, pass_count[5:0], best_nonce[4:0]}, go FINISH.
REQ-027 FINISH edge: mem_we<=0, done<=1, go IDLE; next edge done<=0.
REQ-028 Latency: done high for exactly one cycle after edge NUM_NONCES+4 (edge 20 for default).
REQ-029 start while not IDLE SHALL be ignored; start held high at return to IDLE begins a new scan on the edge following done.
REQ-030 found, best_nonce, best_hash, pass_count SHALL hold final values from FINISH until the next accepted start.
REQ-031 mem_addr arithmetic is 16-bit, wrapping 16'hFFFF -> 16'h0000 for both scan and summary addresses.
REQ-032 mem_we SHALL be 0 in every state except for the two summary writes.

Reset
REQ-033 reset=1 on an edge, in any state, SHALL force IDLE, mem_we=0, done=0, found=0, best_nonce=0, best_hash=32'hFFFFFFFF, pass_count=0, mem_addr=0, mem_write_data=0.
REQ-034 reset SHALL take priority over start; a scan interrupted by reset produces no memory write and no done.

Verification
REQ-035 Words 0..15 = 32'h1000_0000+i*16, target 32'h0000_0001 -> pass_count=0, found=0, best_nonce=0, best_hash=32'h1000_0000, summary words 32'h1000_0000 and 32'h0000_0000, done at edge 20.
REQ-036 Word 9 = 32'h0000_00FF, word 3 = 32'h0000_FFFF, others 32'hFFFF_0000, target 32'h0001_0000 -> pass_count=2, found=1, best_nonce=9, second summary word 32'h8000_0049.
REQ-037 Words 4 and 11 both 32'h0000_0010, rest larger -> best_nonce=4 (tie keeps lower index).
REQ-038 Assert reset at edge 8 of SCAN -> IDLE next edge, mem_we never 1, done never 1; subsequent start completes normally.
REQ-039 hash_addr=16'hFFF8, NUM_NONCES=16 -> addresses FFF8..FFFF then 0000..0007 read in order; start pulsed during SCAN has no effect.
